sobel_filter: RTL and testbench

- Streaming stage directly downstream of the grayscale conversion stage in the sobel_v2 pipeline.
- Pops 8-bit grayscale pixels from an upstream FWFT FIFO in raster order and holds two line buffers plus a 3x3 window.
- Pushes one 8-bit edge-magnitude pixel per input pixel into a downstream FIFO.
- Pixel count out equals pixel count in, per frame.

---
 rtl/sobel_pkg.sv | 19 +
 rtl/sobel_line_buffer.sv | 29 ++
 rtl/sobel_filter.sv | 153 +++++++++++++++
 tb/tb_sobel_filter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants, FSM state encoding and the CLOG2 counter-width macro
// for the sobel_v2 edge-detection stage.
`ifndef CLOG2
`define CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package sobel_pkg;

  localparam int unsigned DEF_DWIDTH = 8;
  localparam int unsigned DEF_WIDTH  = 720;
  localparam int unsigned DEF_HEIGHT = 540;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of delay: a DEPTH-deep shift memory that advances only when
// en is high; dout is the pixel pushed DEPTH shifts ago.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int unsigned DWIDTH = DEF_DWIDTH,
  parameter int unsigned DEPTH  = DEF_WIDTH
) (
  input  logic              clock,
  input  logic              en,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout
);

  logic [DWIDTH-1:0] mem [DEPTH];

  // No reset: contents before the first full row only feed border outputs.
  always_ff @(posedge clock) begin
    if (en) begin
      mem[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel edge-magnitude stage between two FWFT FIFOs.
// Build option: define SOBEL_THRESHOLD_EN to binarize interior outputs against THRESHOLD.
module sobel_filter
  import sobel_pkg::*;
#(
  parameter int unsigned DWIDTH    = DEF_DWIDTH,
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned HEIGHT    = DEF_HEIGHT,
  parameter int unsigned THRESHOLD = 128
) (
  input  logic              clock,
  input  logic              reset,
  output logic              fifo_in_rd_en,
  input  logic [DWIDTH-1:0] fifo_in_dout,
  input  logic              fifo_in_empty,
  output logic              fifo_out_wr_en,
  output logic [DWIDTH-1:0] fifo_out_din,
  input  logic              fifo_out_full
);

  localparam int unsigned CW = `CLOG2(WIDTH);
  localparam int unsigned RW = `CLOG2(HEIGHT);
  localparam int unsigned FW = `CLOG2(WIDTH + 1);
  localparam int unsigned GW = DWIDTH + 3;

  state_t state, state_next;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [FW-1:0]     flush_cnt;
  logic              last_col, last_row, flush_done;
  logic [DWIDTH-1:0] lb1_out, lb2_out;
  logic [DWIDTH-1:0] win [3][2];
  logic [GW-1:0]     gx_pos, gx_neg, gy_pos, gy_neg, gx, gy, ax, ay, mag;
  logic [DWIDTH-1:0] edge_val;
  logic              border;

  assign last_col   = (col == CW'(WIDTH - 1));
  assign last_row   = (row == RW'(HEIGHT - 1));
  assign flush_done = (flush_cnt == FW'(WIDTH));

  sobel_line_buffer #(.DWIDTH(DWIDTH), .DEPTH(WIDTH)) u_lb1 (
    .clock (clock),
    .en    (fifo_in_rd_en),
    .din   (fifo_in_dout),
    .dout  (lb1_out)
  );

  sobel_line_buffer #(.DWIDTH(DWIDTH), .DEPTH(WIDTH)) u_lb2 (
    .clock (clock),
    .en    (fifo_in_rd_en),
    .din   (lb1_out),
    .dout  (lb2_out)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    fifo_in_rd_en = 1'b0;
    unique case (state)
      FILL: begin
        fifo_in_rd_en = !fifo_in_empty && !fifo_out_full;
        if (fifo_in_rd_en && row == RW'(1) && col == '0) state_next = RUN;
      end
      RUN: begin
        fifo_in_rd_en = !fifo_in_empty && !fifo_out_full;
        if (fifo_in_rd_en && last_row && last_col) state_next = FLUSH;
      end
      FLUSH: begin
        if (!fifo_out_full && flush_done) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col       <= '0;
      row       <= '0;
      flush_cnt <= '0;
    end else begin
      if (fifo_in_rd_en) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (state == FLUSH && !fifo_out_full) begin
        flush_cnt <= flush_done ? '0 : flush_cnt + FW'(1);
      end
    end
  end

  // Only two stored columns: the third (newest) column is the live input plus
  // the line-buffer taps, so the output is registered on the consuming edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win[r][0] <= '0;
        win[r][1] <= '0;
      end
    end else if (fifo_in_rd_en) begin
      for (int unsigned r = 0; r < 3; r++) win[r][0] <= win[r][1];
      win[0][1] <= lb2_out;
      win[1][1] <= lb1_out;
      win[2][1] <= fifo_in_dout;
    end
  end

  always_comb begin
    gx_pos = GW'(lb2_out) + (GW'(lb1_out) << 1) + GW'(fifo_in_dout);
    gx_neg = GW'(win[0][0]) + (GW'(win[1][0]) << 1) + GW'(win[2][0]);
    gy_pos = GW'(win[2][0]) + (GW'(win[2][1]) << 1) + GW'(fifo_in_dout);
    gy_neg = GW'(win[0][0]) + (GW'(win[0][1]) << 1) + GW'(lb2_out);
    gx     = gx_pos - gx_neg;
    gy     = gy_pos - gy_neg;
    ax     = gx[GW-1] ? (GW'(0) - gx) : gx;
    ay     = gy[GW-1] ? (GW'(0) - gy) : gy;
    mag    = ax + ay;
`ifdef SOBEL_THRESHOLD_EN
    edge_val = (mag >= GW'(THRESHOLD)) ? '1 : '0;
`else
    edge_val = (mag > GW'({DWIDTH{1'b1}})) ? '1 : mag[DWIDTH-1:0];
`endif
  end

  // Centre lags the input by one row and one column: input cols 0/1 map to
  // centre cols W-1/0, and input row 1 maps to centre row 0.
  assign border = (col <= CW'(1)) || (row == RW'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fifo_out_wr_en <= 1'b0;
      fifo_out_din   <= '0;
    end else begin
      fifo_out_wr_en <= 1'b0;
      if (state == RUN && fifo_in_rd_en) begin
        fifo_out_wr_en <= 1'b1;
        fifo_out_din   <= border ? '0 : edge_val;
      end else if (state == FLUSH && !fifo_out_full) begin
        fifo_out_wr_en <= 1'b1;
        fifo_out_din   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sobel_filter.sv
// Scoreboard bench for sobel_filter on an 8x4 image; honours SOBEL_THRESHOLD_EN.
module tb_sobel_filter;

  localparam int unsigned W = 8;
  localparam int unsigned H = 4;
  localparam int unsigned N = W * H;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       fifo_in_rd_en;
  logic [7:0] fifo_in_dout = '0;
  logic       fifo_in_empty = 1'b1;
  logic       fifo_out_wr_en;
  logic [7:0] fifo_out_din;
  logic       fifo_out_full = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_writes = 0;

  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] frame [N];
  bit         gap_en = 1'b0;
  bit         full_drv = 1'b0;
  bit         pop_pending = 1'b0;

  sobel_filter #(.DWIDTH(8), .WIDTH(W), .HEIGHT(H), .THRESHOLD(128)) dut (
    .clock          (clock),
    .reset          (reset),
    .fifo_in_rd_en  (fifo_in_rd_en),
    .fifo_in_dout   (fifo_in_dout),
    .fifo_in_empty  (fifo_in_empty),
    .fifo_out_wr_en (fifo_out_wr_en),
    .fifo_out_din   (fifo_out_din),
    .fifo_out_full  (fifo_out_full)
  );

  initial forever #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int px(input int r, input int c);
    return int'(frame[r * W + c]);
  endfunction

  function automatic logic [7:0] golden(input int r, input int c);
    int gx, gy, mag;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'd0;
    gx = px(r-1, c+1) + 2 * px(r, c+1) + px(r+1, c+1)
       - px(r-1, c-1) - 2 * px(r, c-1) - px(r+1, c-1);
    gy = px(r+1, c-1) + 2 * px(r+1, c) + px(r+1, c+1)
       - px(r-1, c-1) - 2 * px(r-1, c) - px(r-1, c+1);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESHOLD_EN
    return (mag >= 128) ? 8'd255 : 8'd0;
`else
    return (mag > 255) ? 8'd255 : 8'(mag);
`endif
  endfunction

  // Pushes the current frame into the source and its golden outputs into the scoreboard.
  task automatic push_frame(input int unsigned n_pix);
    for (int r = 0; r < int'(H); r++)
      for (int c = 0; c < int'(W); c++) exp_q.push_back(golden(r, c));
    for (int unsigned i = 0; i < n_pix; i++) src_q.push_back(frame[i]);
  endtask

  task automatic drain();
    int unsigned cyc = 0;
    while ((exp_q.size() != 0 || src_q.size() != 0) && cyc < 3000) begin
      @(negedge clock);
      cyc++;
    end
    check_eq("drain_left", exp_q.size(), 0);
    repeat (W + 4) @(negedge clock);
  endtask

  // Upstream FWFT FIFO and downstream full, updated away from the active edge.
  initial forever begin
    @(negedge clock);
    fifo_in_dout  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    fifo_in_empty = (src_q.size() == 0) || (gap_en && $urandom_range(0, 1) == 1);
    fifo_out_full = full_drv;
  end

  initial forever begin
    @(posedge clock);
    if (pop_pending && reset && src_q.size() > 0) void'(src_q.pop_front());
    pop_pending = 1'b0;
  end

  initial forever begin
    logic [7:0] want;
    @(negedge clock);
    #1;
    pop_pending = fifo_in_rd_en && reset;
    if (fifo_out_full) check_eq("rd_while_full", fifo_in_rd_en, 0);
    if (fifo_out_wr_en === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) check_eq("spurious_wr_en", fifo_out_wr_en, 0);
      else begin
        want = exp_q.pop_front();
        check_eq("pixel", fifo_out_din, want);
      end
    end
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w0, cyc;

    repeat (3) @(negedge clock);
    #2;
    check_eq("rst_wr_en", fifo_out_wr_en, 0);
    check_eq("rst_din", fifo_out_din, 0);
    check_eq("rst_rd_en", fifo_in_rd_en, 0);
    reset = 1'b1;

    // Flat image: no edges anywhere.
    for (int i = 0; i < int'(N); i++) frame[i] = 8'd100;
    w0 = n_writes;
    push_frame(N);
    drain();
    check_eq("flat_writes", n_writes - w0, N);

    // Vertical step between cols 3 and 4.
    for (int i = 0; i < int'(N); i++) frame[i] = ((i % W) < 4) ? 8'd0 : 8'd200;
    check_eq("step_r1c3", golden(1, 3), 255);
    check_eq("step_r2c4", golden(2, 4), 255);
    w0 = n_writes;
    push_frame(N);
    drain();
    check_eq("step_writes", n_writes - w0, N);

    // Backpressure for 10 cycles in the middle of RUN.
    for (int i = 0; i < int'(N); i++) frame[i] = 8'($urandom_range(0, 255));
    w0 = n_writes;
    push_frame(N);
    cyc = 0;
    while (n_writes < w0 + 5 && cyc < 500) begin
      @(negedge clock);
      cyc++;
    end
    check_eq("stall_start", (n_writes >= w0 + 5), 1);
    full_drv = 1'b1;
    repeat (11) @(negedge clock);
    full_drv = 1'b0;
    drain();
    check_eq("stall_writes", n_writes - w0, N);

    // Two back-to-back frames with random empty gaps.
    gap_en = 1'b1;
    w0 = n_writes;
    for (int i = 0; i < int'(N); i++) frame[i] = 8'($urandom_range(0, 255));
    push_frame(N);
    for (int i = 0; i < int'(N); i++) frame[i] = 8'($urandom_range(0, 255));
    push_frame(N);
    drain();
    gap_en = 1'b0;
    check_eq("gap_writes", n_writes - w0, 2 * N);

    // Abort after 13 pixels, right as the output for pixel 12 is being written.
    for (int i = 0; i < int'(N); i++) frame[i] = 8'($urandom_range(0, 255));
    w0 = n_writes;
    push_frame(13);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (src_q.size() != 0 && cyc < 500);
    #2;
    reset = 1'b0;
    #1;
    check_eq("abort_wr_en", fifo_out_wr_en, 0);
    check_eq("abort_din", fifo_out_din, 0);
    check_eq("pre_reset_writes", n_writes - w0, 4);
    exp_q.delete();
    @(negedge clock);
    #2;
    reset = 1'b1;
    for (int i = 0; i < int'(N); i++) frame[i] = 8'($urandom_range(0, 255));
    w0 = n_writes;
    push_frame(N);
    drain();
    check_eq("post_reset_writes", n_writes - w0, N);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
